// File: rtl/seq_au_pkg.sv
// Shared encodings for the slice-serial arithmetic unit: op select values and FSM states.
package seq_au_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/au_slice.sv
// Combinational SLICE-bit ripple full-adder chain; also exposes the carry into its MSB
// so the top level can form signed overflow on the most significant slice.
module au_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
            assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[SLICE];
    assign cmsb = c[SLICE-1];

endmodule

// File: rtl/seq_arithmetic_unit.sv
// Slice-serial add/sub/inc/dec unit: one SLICE-bit slice per clock, LSB first, with a
// registered inter-slice carry. Define SEQ_AU_FLAGS_EN to build the Z/V flag logic.
module seq_arithmetic_unit
    import seq_au_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] D,
    output logic             C_out,
    output logic             Z,
    output logic             V
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_reg, b_reg, d_reg, d_next, b_prep;
    logic               c_out_reg, valid_reg;
    logic               accept, step, last;
    logic [SLICE-1:0]   slice_a, slice_b, slice_sum;
    logic               slice_cout, slice_cmsb;

    // B is folded through the op mux at accept so the slice engine only ever adds.
    always_comb begin
        case (S)
            OP_ADD:  b_prep = B;
            OP_SUB:  b_prep = ~B;
            OP_INC:  b_prep = '0;
            default: b_prep = '1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_BUSY;
            ST_BUSY: if (last)  state_next = ST_IDLE;
            default:            state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready  = (state_reg == ST_IDLE);
        step   = (state_reg == ST_BUSY);
        accept = ready && start;
    end

    assign last    = (idx_reg == IDX_W'(N - 1));
    assign slice_a = a_reg[idx_reg*SLICE +: SLICE];
    assign slice_b = b_reg[idx_reg*SLICE +: SLICE];

    au_slice #(.SLICE(SLICE)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    always_comb begin
        d_next = d_reg;
        d_next[idx_reg*SLICE +: SLICE] = slice_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            d_reg     <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            c_out_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= step && last;
            if (accept) begin
                a_reg     <= A;
                b_reg     <= b_prep;
                carry_reg <= C_in;
                idx_reg   <= '0;
            end else if (step) begin
                d_reg     <= d_next;
                carry_reg <= slice_cout;
                idx_reg   <= last ? '0 : idx_reg + IDX_W'(1);
                if (last) c_out_reg <= slice_cout;
            end
        end
    end

`ifdef SEQ_AU_FLAGS_EN
    logic z_reg, v_reg;

    // The last step processes the MSB slice, so its carries give signed overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_reg <= 1'b1;
            v_reg <= 1'b0;
        end else if (step && last) begin
            z_reg <= (d_next == '0);
            v_reg <= slice_cmsb ^ slice_cout;
        end
    end

    assign Z = z_reg;
    assign V = v_reg;
`else
    logic unused_cmsb;
    assign unused_cmsb = slice_cmsb;
    assign Z = 1'b0;
    assign V = 1'b0;
`endif

    assign valid = valid_reg;
    assign D     = d_reg;
    assign C_out = c_out_reg;

endmodule

// File: tb/tb_seq_arithmetic_unit.sv
// Bench for seq_arithmetic_unit: 8/4 and 16/4 instances checked against a plain-arithmetic
// model, with table vectors, random ops and hand-written busy/back-to-back/reset sequences.
module tb_seq_arithmetic_unit;

`ifdef SEQ_AU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        st8, ci8, rdy8, val8, co8, z8, v8;
    logic [1:0]  s8;
    logic [7:0]  a8, b8, d8;
    logic        st16, ci16, rdy16, val16, co16, z16, v16;
    logic [1:0]  s16;
    logic [15:0] a16, b16, d16;

    seq_arithmetic_unit #(.WIDTH(8), .SLICE(4)) u8 (
        .clk(clk), .rst(rst), .start(st8), .S(s8), .A(a8), .B(b8), .C_in(ci8),
        .ready(rdy8), .valid(val8), .D(d8), .C_out(co8), .Z(z8), .V(v8));

    seq_arithmetic_unit #(.WIDTH(16), .SLICE(4)) u16 (
        .clk(clk), .rst(rst), .start(st16), .S(s16), .A(a16), .B(b16), .C_in(ci16),
        .ready(rdy16), .valid(val16), .D(d16), .C_out(co16), .Z(z16), .V(v16));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] a, b;
        logic [1:0] s;
        logic       cin;
        logic [7:0] d;
        logic       c, z, v;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: the whole operation as one wide integer add.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] s, input logic cin,
                                  output logic [15:0] d, output logic c,
                                  output logic z, output logic v);
        longint unsigned mask, bp, full, av, dv;
        mask = (64'd1 << w) - 1;
        av   = longint'(a) & mask;
        case (s)
            2'd0:    bp = longint'(b) & mask;
            2'd1:    bp = ~longint'(b) & mask;
            2'd2:    bp = 0;
            default: bp = mask;
        endcase
        full = av + bp + longint'(cin);
        dv   = full & mask;
        d    = 16'(dv);
        c    = full[w];
        z    = (dv == 0);
        v    = (av[w-1] == bp[w-1]) && (dv[w-1] != av[w-1]);
    endfunction

    task automatic drive(input bit w, input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] s, input logic ci);
        if (w) begin
            st16 = st; a16 = a; b16 = b; s16 = s; ci16 = ci;
        end else begin
            st8 = st; a8 = a[7:0]; b8 = b[7:0]; s8 = s; ci8 = ci;
        end
    endtask

    task automatic sample(input bit w, output logic vl, output logic rd, output logic [15:0] d,
                          output logic c, output logic z, output logic v);
        if (w) begin
            vl = val16; rd = rdy16; d = d16; c = co16; z = z16; v = v16;
        end else begin
            vl = val8; rd = rdy8; d = {8'h00, d8}; c = co8; z = z8; v = v8;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, scramble the inputs after accept, then check latency and result.
    task automatic do_op(input bit w, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] s, input logic cin, input string tag);
        logic [15:0] ed, gd;
        logic ec, ez, ev, gv, gr, gc, gz, gvv;
        int n, cyc, wd, nslice;
        wd = w ? 16 : 8;
        nslice = wd / 4;
        model(wd, a, b, s, cin, ed, ec, ez, ev);
        n = 0;
        sample(w, gv, gr, gd, gc, gz, gvv);
        while (!gr && n < 50) begin
            tick(); n++;
            sample(w, gv, gr, gd, gc, gz, gvv);
        end
        chk({tag, " ready_before_start"}, 32'(gr), 32'd1);
        drive(w, 1'b1, a, b, s, cin);
        tick();
        drive(w, 1'b0, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
        cyc = 0;
        do begin
            tick(); cyc++;
            sample(w, gv, gr, gd, gc, gz, gvv);
        end while (!gv && cyc < 20);
        $display("[TB] %s W=%0d A=%h B=%h S=%0d Cin=%0d -> D=%h C=%0d Z=%0d V=%0d after %0d cycles",
                 tag, wd, a, b, s, cin, gd, gc, gz, gvv, cyc);
        chk({tag, " latency"}, 32'(cyc), 32'(nslice));
        chk({tag, " ready_with_valid"}, 32'(gr), 32'd1);
        chk({tag, " D"}, 32'(gd), 32'(ed));
        chk({tag, " C_out"}, 32'(gc), 32'(ec));
        chk({tag, " Z"}, 32'(gz), 32'(ez & FLAGS));
        chk({tag, " V"}, 32'(gvv), 32'(ev & FLAGS));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ready8"}, 32'(rdy8), 32'd1);
        chk({tag, " valid8"}, 32'(val8), 32'd0);
        chk({tag, " D8"}, 32'(d8), 32'd0);
        chk({tag, " C8"}, 32'(co8), 32'd0);
        chk({tag, " Z8"}, 32'(z8), 32'(FLAGS));
        chk({tag, " V8"}, 32'(v8), 32'd0);
        chk({tag, " ready16"}, 32'(rdy16), 32'd1);
        chk({tag, " valid16"}, 32'(val16), 32'd0);
        chk({tag, " D16"}, 32'(d16), 32'd0);
        chk({tag, " C16"}, 32'(co16), 32'd0);
        chk({tag, " Z16"}, 32'(z16), 32'(FLAGS));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nval;
        logic [15:0] gd;
        logic gv, gr, gc, gz, gvv;

        tbl[0] = '{8'h55, 8'h33, 2'd0, 1'b0, 8'h88, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{8'h55, 8'h33, 2'd1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h55, 8'h33, 2'd0, 1'b1, 8'h89, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 8'h5A, 2'd2, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 8'hC3, 2'd3, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h7F, 8'h01, 2'd0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{8'h80, 8'h00, 2'd3, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{8'h80, 8'h80, 2'd1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
        tick(); tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Table vectors on the 8/4 instance, with hand-computed expectations.
        foreach (tbl[i]) begin
            drive(1'b0, 1'b1, {8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].s, tbl[i].cin);
            tick();
            drive(1'b0, 1'b0, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
            cyc = 0;
            do begin
                tick(); cyc++;
                sample(1'b0, gv, gr, gd, gc, gz, gvv);
            end while (!gv && cyc < 20);
            $display("[TB] tbl%0d A=%h B=%h S=%0d Cin=%0d -> D=%h C=%0d Z=%0d V=%0d after %0d cycles",
                     i, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].cin, gd[7:0], gc, gz, gvv, cyc);
            chk($sformatf("tbl%0d latency", i), 32'(cyc), 32'd2);
            chk($sformatf("tbl%0d D", i), 32'(gd[7:0]), 32'(tbl[i].d));
            chk($sformatf("tbl%0d C_out", i), 32'(gc), 32'(tbl[i].c));
            chk($sformatf("tbl%0d Z", i), 32'(gz), 32'(tbl[i].z & FLAGS));
            chk($sformatf("tbl%0d V", i), 32'(gvv), 32'(tbl[i].v & FLAGS));
            tick();
            sample(1'b0, gv, gr, gd, gc, gz, gvv);
            chk($sformatf("tbl%0d valid_pulse", i), 32'(gv), 32'd0);
        end

        do_op(1'b1, 16'h0FFF, 16'h0001, 2'd0, 1'b0, "w16_carry_chain");

        // start pulse while busy must be ignored, not queued.
        drive(1'b1, 1'b1, 16'h0FFF, 16'h0001, 2'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'hAAAA, 16'h5555, 2'd1, 1'b1);
        tick();
        drive(1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
        cyc = 2;
        do begin
            tick(); cyc++;
            sample(1'b1, gv, gr, gd, gc, gz, gvv);
        end while (!gv && cyc < 20);
        $display("[TB] busy_start D=%h after %0d cycles", gd, cyc);
        chk("busy_start latency", 32'(cyc), 32'd4);
        chk("busy_start D", 32'(gd), 32'h1000);
        nval = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (val16) nval++;
        end
        chk("busy_start no_queued_op", 32'(nval), 32'd0);

        // Back-to-back: start asserted in the valid cycle is accepted.
        drive(1'b1, 1'b1, 16'h1234, 16'h1111, 2'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
        cyc = 0;
        do begin
            tick(); cyc++;
            sample(1'b1, gv, gr, gd, gc, gz, gvv);
        end while (!gv && cyc < 20);
        $display("[TB] b2b first D=%h after %0d cycles", gd, cyc);
        chk("b2b first D", 32'(gd), 32'h2345);
        chk("b2b first ready", 32'(gr), 32'd1);
        drive(1'b1, 1'b1, 16'hFFFF, 16'h0000, 2'd2, 1'b1);
        tick();
        drive(1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
        chk("b2b accepted ready_low", 32'(rdy16), 32'd0);
        cyc = 0;
        do begin
            tick(); cyc++;
            sample(1'b1, gv, gr, gd, gc, gz, gvv);
        end while (!gv && cyc < 20);
        $display("[TB] b2b second D=%h C=%0d Z=%0d after %0d cycles", gd, gc, gz, cyc);
        chk("b2b second latency", 32'(cyc), 32'd4);
        chk("b2b second D", 32'(gd), 32'h0000);
        chk("b2b second C_out", 32'(gc), 32'd1);
        chk("b2b second Z", 32'(gz), 32'(FLAGS));

        // Reset in the second busy cycle aborts the operation asynchronously.
        drive(1'b1, 1'b1, 16'h00FF, 16'h0001, 2'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        $display("[TB] async reset mid-op: ready=%0d valid=%0d D=%h", rdy16, val16, d16);
        chk_reset_vals("midop_reset");
        tick();
        rst = 1'b0;
        nval = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (val16) nval++;
        end
        chk("midop_reset no_valid", 32'(nval), 32'd0);
        do_op(1'b1, 16'h00FF, 16'h0001, 2'd0, 1'b0, "after_reset");

        for (int k = 0; k < 30; k++) begin
            do_op(1'b0, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
                  $sformatf("rnd8_%0d", k));
            do_op(1'b1, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
                  $sformatf("rnd16_%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
